// File: rtl/ttc_clk_pkg.sv
// Shared types and constants for the TTC clock-enable scheduler.
package ttc_clk_pkg;

   // Default width of the divisor and the period counter
   localparam int unsigned DEF_CNT_W = 16;

   // Smallest divisor that still yields a distinct tick and phase
   localparam int unsigned DIV_MIN = 2;

   // Scheduler states: STOP keeps counting until the period boundary
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      STOP = 2'd2
   } state_e;

endpackage

// File: rtl/ttc_period_cnt.sv
// Period counter with boundary detect and the active divisor register.
module ttc_period_cnt
   import ttc_clk_pkg::*;
#(
   parameter int unsigned CNT_W   = DEF_CNT_W,
   parameter int unsigned DEF_DIV = 16
) (
   input  logic             clk,
   input  logic             init,
   input  logic             en,
   input  logic             load,
   input  logic [CNT_W-1:0] load_div,
   output logic [CNT_W-1:0] cnt,
   output logic [CNT_W-1:0] cur_div,
   output logic             boundary_c
);

   // Last cycle of a period; never true while disabled
   assign boundary_c = en & (cnt == (cur_div - CNT_W'(1)));

   // Count 0..cur_div-1 while enabled, hold at 0 otherwise
   always_ff @(posedge clk or posedge init) begin
      if (init) begin
         cnt <= '0;
      end else if (!en || boundary_c) begin
         cnt <= '0;
      end else begin
         cnt <= cnt + CNT_W'(1);
      end
   end

   // Active divisor, replaced only when the controller says so
   always_ff @(posedge clk or posedge init) begin
      if (init) begin
         cur_div <= CNT_W'(DEF_DIV);
      end else if (load) begin
         cur_div <= load_div;
      end
   end

endmodule

// File: rtl/ttc_rate_ctrl.sv
// Programmable clock-enable scheduler: run/stop sequencing, config slot,
// and decode of tick/phase/half from the period counter.
module ttc_rate_ctrl
   import ttc_clk_pkg::*;
#(
   parameter int unsigned CNT_W   = DEF_CNT_W,
   parameter int unsigned DEF_DIV = 16
) (
   input  logic             clk,
   input  logic             init,
   input  logic             run_req,
   input  logic             cfg_valid,
   input  logic [CNT_W-1:0] cfg_div,
   output logic             cfg_ready,
   output logic             tick,
   output logic             phase,
   output logic             half,
   output logic             running,
   output logic             cfg_err,
   output logic [CNT_W-1:0] cur_div
);

   state_e           state_q;
   state_e           state_d;
   logic             pend_vld_q;
   logic             pend_vld_d;
   logic [CNT_W-1:0] pend_div_q;
   logic [CNT_W-1:0] pend_div_d;
   logic             err_q;
   logic             err_d;
   logic             half_q;
   logic             load_c;
   logic [CNT_W-1:0] load_div_c;
   logic             accept_c;
   logic             div_ok_c;
   logic             boundary_c;
   logic [CNT_W-1:0] cnt;

   ttc_period_cnt #(
      .CNT_W   (CNT_W),
      .DEF_DIV (DEF_DIV)
   ) u_period_cnt (
      .clk        (clk),
      .init       (init),
      .en         (running),
      .load       (load_c),
      .load_div   (load_div_c),
      .cnt        (cnt),
      .cur_div    (cur_div),
      .boundary_c (boundary_c)
   );

   // State, config slot and error pulse registers
   always_ff @(posedge clk or posedge init) begin
      if (init) begin
         state_q    <= IDLE;
         pend_vld_q <= 1'b0;
         pend_div_q <= '0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         pend_vld_q <= pend_vld_d;
         pend_div_q <= pend_div_d;
         err_q      <= err_d;
      end
   end

   // Next state, divisor apply and config slot handling
   always_comb begin
      state_d    = state_q;
      pend_vld_d = pend_vld_q;
      pend_div_d = pend_div_q;
      err_d      = 1'b0;
      load_c     = 1'b0;
      load_div_c = pend_div_q;
      accept_c   = cfg_valid & ~pend_vld_q;
      div_ok_c   = (cfg_div >= CNT_W'(DIV_MIN));

      case (state_q)
         IDLE: begin
            if (run_req) state_d = RUN;
         end
         RUN: begin
            // A drop sampled on the last cycle still completes that period
            if (!run_req) state_d = boundary_c ? IDLE : STOP;
         end
         STOP: begin
            if (run_req)         state_d = RUN;
            else if (boundary_c) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase

      // Pending divisor takes effect when idle or at a period boundary
      if (pend_vld_q && ((state_q == IDLE) || boundary_c)) begin
         load_c     = 1'b1;
         load_div_c = pend_div_q;
         pend_vld_d = 1'b0;
      end

      // Slot is empty whenever accept_c is set, so no clash with the apply above
      if (accept_c) begin
         if (!div_ok_c) begin
            err_d = 1'b1;
         end else if (boundary_c) begin
            load_c     = 1'b1;
            load_div_c = cfg_div;
         end else begin
            pend_vld_d = 1'b1;
            pend_div_d = cfg_div;
         end
      end
   end

   // clk/2 toggle, forced low whenever the scheduler is idle
   always_ff @(posedge clk or posedge init) begin
      if (init) begin
         half_q <= 1'b0;
      end else if (state_d == IDLE) begin
         half_q <= 1'b0;
      end else begin
         half_q <= ~half_q;
      end
   end

   // Output decode from registered state only
   assign running   = (state_q != IDLE);
   assign cfg_ready = ~pend_vld_q;
   assign cfg_err   = err_q;
   assign half      = half_q;
   assign tick      = running & (cnt == '0);
   assign phase     = running & (cnt < (cur_div >> 1));

endmodule
